// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO owner and issue/retire controller for the multiply/divide unit
module hilo_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  output logic        stall,
  output logic [31:0] hilo_rdata,
  output logic        busy,
  output logic [31:0] mdu_src0,
  output logic [31:0] mdu_src1,
  output logic [1:0]  mdu_op,
  output logic        mdu_sign,
  output logic        mdu_in_valid,
  input  logic        mdu_in_ready,
  input  logic        mdu_out_valid,
  output logic        mdu_out_ready,
  input  logic [31:0] mdu_res0,
  input  logic [31:0] mdu_res1
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state;
  logic [31:0] hi, lo;
  logic        start, hilo;
  assign mdu_src0 = e_rs;
  assign mdu_src1 = e_rt;
  // reset gating keeps the launch/stall/read outputs quiet while reset is held
  always_comb begin
    start         = e_valid && e_op >= 4'd1 && e_op <= 4'd4;
    hilo          = e_valid && e_op >= 4'd1 && e_op <= 4'd8;
    busy          = state == WAIT;
    mdu_in_valid  = reset && !busy && start;
    mdu_out_ready = busy;
    stall         = reset && hilo && (busy || (start && !mdu_in_ready));
    hilo_rdata    = !reset ? 32'd0 : (e_valid && e_op == 4'd7) ? hi : (e_valid && e_op == 4'd8) ? lo : 32'd0;
    mdu_op        = !start ? 2'd0 : e_op <= 4'd2 ? 2'd1 : 2'd2;
    mdu_sign      = start && (e_op == 4'd1 || e_op == 4'd3);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else if (busy) begin
      if (mdu_out_valid) begin
        lo    <= mdu_res0;
        hi    <= mdu_res1;
        state <= IDLE;
      end
    end else if (start && mdu_in_ready) begin
      state <= WAIT;
    end else if (e_valid && e_op == 4'd5) begin
      hi <= e_rs;
    end else if (e_valid && e_op == 4'd6) begin
      lo <= e_rs;
    end
  end
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed bench with a behavioural MDU, a HI/LO reference model and per-cycle checking
module tb_hilo_ctrl;
  logic        clock = 1'b0, reset = 1'b0, e_valid = 1'b0;
  logic [3:0]  e_op = 4'd0;
  logic [31:0] e_rs = 32'd0, e_rt = 32'd0;
  logic        stall, busy, mdu_sign, mdu_in_valid, mdu_in_ready, mdu_out_valid, mdu_out_ready;
  logic [31:0] hilo_rdata, mdu_src0, mdu_src1, mdu_res0, mdu_res1;
  logic [1:0]  mdu_op;
  int          n_chk = 0, n_fail = 0;
  hilo_ctrl dut (
    .clock(clock), .reset(reset), .e_valid(e_valid), .e_op(e_op), .e_rs(e_rs), .e_rt(e_rt),
    .stall(stall), .hilo_rdata(hilo_rdata), .busy(busy), .mdu_src0(mdu_src0), .mdu_src1(mdu_src1),
    .mdu_op(mdu_op), .mdu_sign(mdu_sign), .mdu_in_valid(mdu_in_valid), .mdu_in_ready(mdu_in_ready),
    .mdu_out_valid(mdu_out_valid), .mdu_out_ready(mdu_out_ready), .mdu_res0(mdu_res0), .mdu_res1(mdu_res1)
  );
  always #5 clock = ~clock;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Behavioural multiply/divide unit: multiply answers the cycle after launch, divide after div_lat extra cycles
  logic        ready_en = 1'b1, spurious = 1'b0, u_pend;
  int          div_lat = 3, u_cnt;
  logic [31:0] u_r0, u_r1;
  function automatic logic [63:0] calc(input logic [1:0] op, input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a)), sb = longint'($signed(b));
    longint ua = longint'({32'd0, a}), ub = longint'({32'd0, b});
    if (op == 2'd1) return sg ? 64'(sa * sb) : 64'(ua * ub);
    return sg ? {32'(sa % sb), 32'(sa / sb)} : {32'(ua % ub), 32'(ua / ub)};
  endfunction
  assign mdu_in_ready  = ready_en && !u_pend;
  assign mdu_out_valid = (u_pend && u_cnt == 0) || spurious;
  assign mdu_res0      = u_pend ? u_r0 : 32'hDEADBEEF;
  assign mdu_res1      = u_pend ? u_r1 : 32'hBADC0FFE;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      u_pend <= 1'b0;
      u_cnt  <= 0;
    end else if (u_pend) begin
      if (mdu_out_valid && mdu_out_ready) u_pend <= 1'b0;
      else if (u_cnt != 0) u_cnt <= u_cnt - 1;
    end else if (mdu_in_valid && mdu_in_ready) begin
      u_pend <= 1'b1;
      u_cnt  <= mdu_op == 2'd1 ? 0 : div_lat;
      {u_r1, u_r0} <= calc(mdu_op, mdu_sign, mdu_src0, mdu_src1);
    end
  end
  // Reference architectural state: HI, LO and whether an operation is outstanding
  logic [31:0] m_hi, m_lo;
  logic        m_busy;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_busy <= 1'b0;
    end else if (m_busy) begin
      if (mdu_out_valid) begin
        m_hi <= mdu_res1; m_lo <= mdu_res0; m_busy <= 1'b0;
      end
    end else if (e_valid) begin
      case (e_op)
        4'd1, 4'd2, 4'd3, 4'd4: m_busy <= mdu_in_ready;
        4'd5: m_hi <= e_rs;
        4'd6: m_lo <= e_rs;
        default: ;
      endcase
    end
  end
  always @(negedge clock) begin
    logic        is_start, is_hilo, e_stall, e_sign;
    logic [1:0]  e_mop;
    logic [31:0] e_rd;
    is_start = e_valid && (e_op inside {[4'd1:4'd4]});
    is_hilo  = e_valid && (e_op inside {[4'd1:4'd8]});
    e_stall  = reset && is_hilo && (m_busy || (is_start && !mdu_in_ready));
    e_mop    = 2'd0;
    e_sign   = 1'b0;
    e_rd     = 32'd0;
    if (e_valid) begin
      case (e_op)
        4'd1: begin e_mop = 2'd1; e_sign = 1'b1; end
        4'd2: e_mop = 2'd1;
        4'd3: begin e_mop = 2'd2; e_sign = 1'b1; end
        4'd4: e_mop = 2'd2;
        4'd7: e_rd = reset ? m_hi : 32'd0;
        4'd8: e_rd = reset ? m_lo : 32'd0;
        default: ;
      endcase
    end
    chk("stall", 32'(stall), 32'(e_stall));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("in_valid", 32'(mdu_in_valid), 32'(reset && !m_busy && is_start));
    chk("out_ready", 32'(mdu_out_ready), 32'(m_busy));
    chk("hilo_rdata", hilo_rdata, e_rd);
    chk("mdu_op", 32'(mdu_op), 32'(e_mop));
    chk("mdu_sign", 32'(mdu_sign), 32'(e_sign));
    chk("src0", mdu_src0, e_rs);
    chk("src1", mdu_src1, e_rt);
  end
  // Present one instruction, hold it until it is no longer stalled, report stall cycles and read data
  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output int stalls, output logic [31:0] rd);
    e_valid = 1'b1; e_op = op; e_rs = rs; e_rt = rt; stalls = 0;
    @(negedge clock);
    while (stall && stalls < 100) begin
      stalls++;
      @(negedge clock);
    end
    if (stall) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout op=%0d: actual stall 1 required 0", op);
    end
    rd = hilo_rdata;
    @(posedge clock); #1;
    e_valid = 1'b0; e_op = 4'd0;
  endtask
  initial begin
    int          s;
    logic [31:0] r;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    issue(4'd5, 32'h12345678, 32'd0, s, r); chk("mthi_stall", s, 0);
    issue(4'd6, 32'h9ABCDEF0, 32'd0, s, r); chk("mtlo_stall", s, 0);
    issue(4'd7, 32'd0, 32'd0, s, r); chk("mfhi_init", r, 32'h12345678); chk("mfhi_stall", s, 0);
    issue(4'd8, 32'd0, 32'd0, s, r); chk("mflo_init", r, 32'h9ABCDEF0);
    issue(4'd1, 32'hFFFFFFFE, 32'd3, s, r); chk("mult_launch_stall", s, 0);
    issue(4'd8, 32'd0, 32'd0, s, r); chk("mult_mflo_stall", s, 1); chk("mult_lo", r, 32'hFFFFFFFA);
    issue(4'd7, 32'd0, 32'd0, s, r); chk("mult_hi", r, 32'hFFFFFFFF);
    issue(4'd2, 32'hFFFFFFFE, 32'd3, s, r);
    issue(4'd7, 32'd0, 32'd0, s, r); chk("multu_hi", r, 32'h00000002); chk("multu_stall", s, 1);
    issue(4'd8, 32'd0, 32'd0, s, r); chk("multu_lo", r, 32'hFFFFFFFA);
    div_lat = 3;
    issue(4'd3, 32'hFFFFFFF9, 32'd2, s, r);
    issue(4'd7, 32'd0, 32'd0, s, r); chk("div_stall", s, 4); chk("div_hi", r, 32'hFFFFFFFF);
    issue(4'd8, 32'd0, 32'd0, s, r); chk("div_lo", r, 32'hFFFFFFFD);
    issue(4'd4, 32'd100, 32'd7, s, r);
    issue(4'd8, 32'd0, 32'd0, s, r); chk("divu_lo", r, 32'd14);
    issue(4'd7, 32'd0, 32'd0, s, r); chk("divu_hi", r, 32'd2);
    issue(4'd3, 32'd64, 32'd3, s, r);
    issue(4'd6, 32'h55, 32'd0, s, r); chk("mtlo_busy_stall", s, 4);
    issue(4'd8, 32'd0, 32'd0, s, r); chk("mtlo_after_div", r, 32'h55);
    issue(4'd7, 32'd0, 32'd0, s, r); chk("div_rem_kept", r, 32'd1);
    div_lat = 5;
    issue(4'd3, 32'd1000, 32'd10, s, r);
    for (int i = 0; i < 4; i++) begin
      issue(4'd0, 32'd0, 32'd0, s, r); chk("nonhilo_wait_stall", s, 0);
    end
    issue(4'd8, 32'd0, 32'd0, s, r); chk("late_mflo_stall", s, 2); chk("div1000_lo", r, 32'd100);
    div_lat = 2;
    issue(4'd3, 32'd9, 32'd2, s, r);
    issue(4'd2, 32'd3, 32'd4, s, r); chk("b2b_stall", s, 3);
    issue(4'd8, 32'd0, 32'd0, s, r); chk("b2b_lo", r, 32'd12); chk("b2b_mflo_stall", s, 1);
    ready_en = 1'b0;
    e_valid = 1'b1; e_op = 4'd1; e_rs = 32'd5; e_rt = 32'd7;
    @(negedge clock); chk("notready_stall", 32'(stall), 32'd1); chk("notready_inv", 32'(mdu_in_valid), 32'd1);
    @(negedge clock); chk("notready_idle", 32'(busy), 32'd0);
    @(posedge clock); #1; ready_en = 1'b1;
    @(negedge clock); chk("ready_stall", 32'(stall), 32'd0);
    @(posedge clock); #1; e_valid = 1'b0; e_op = 4'd0;
    issue(4'd8, 32'd0, 32'd0, s, r); chk("notready_lo", r, 32'd35);
    issue(4'd5, 32'h0000AAAA, 32'd0, s, r);
    spurious = 1'b1;
    @(posedge clock); #1; spurious = 1'b0;
    issue(4'd7, 32'd0, 32'd0, s, r); chk("spurious_ignored_hi", r, 32'h0000AAAA);
    issue(4'd8, 32'd0, 32'd0, s, r); chk("spurious_ignored_lo", r, 32'd35);
    div_lat = 10;
    issue(4'd3, 32'd77, 32'd5, s, r);
    issue(4'd0, 32'd0, 32'd0, s, r);
    #2; reset = 1'b0;
    #1; chk("reset_busy_drop", 32'(busy), 32'd0); chk("reset_out_ready", 32'(mdu_out_ready), 32'd0);
    @(posedge clock); #1; reset = 1'b1;
    for (int i = 0; i < 12; i++) issue(4'd0, 32'd0, 32'd0, s, r);
    issue(4'd7, 32'd0, 32'd0, s, r); chk("post_reset_hi", r, 32'd0);
    issue(4'd8, 32'd0, 32'd0, s, r); chk("post_reset_lo", r, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
